// File: rtl/emu_run_ctrl_if.sv
// Settings/status bundle between the run-state sequencer and its host/datapath.
// slave is the sequencer side; master drives settings and time, observes status.
interface emu_run_ctrl_if #(
    parameter int unsigned TIME_WIDTH = 64,
    parameter int unsigned CFG_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic [CFG_WIDTH-1:0]  cfg_ext;
    logic [TIME_WIDTH-1:0] start_time_ext;
    logic [TIME_WIDTH-1:0] stop_time_ext;
    logic [TIME_WIDTH-1:0] time_curr;
    logic                  time_adv;
    logic                  soft_restart;

    logic                  emu_rst;
    logic                  emu_en;
    logic [CFG_WIDTH-1:0]  cfg;
    logic                  record_en;
    logic [2:0]            run_state;
    logic                  done_pulse;
    logic [CNT_WIDTH-1:0]  run_steps;

    modport master (
        output cfg_ext, start_time_ext, stop_time_ext, time_curr, time_adv, soft_restart,
        input  emu_rst, emu_en, cfg, record_en, run_state, done_pulse, run_steps
    );

    modport slave (
        input  cfg_ext, start_time_ext, stop_time_ext, time_curr, time_adv, soft_restart,
        output emu_rst, emu_en, cfg, record_en, run_state, done_pulse, run_steps
    );
endinterface

// File: rtl/emu_run_ctrl.sv
// Run-state sequencer for the link emulator: holds the datapath in reset, latches settings,
// enables time advance and gates loopback recording between start and stop times.
module emu_run_ctrl #(
    parameter int unsigned TIME_WIDTH      = 64,
    parameter int unsigned CFG_WIDTH       = 64,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    emu_run_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StInReset = 3'b100,
        StWaiting = 3'b000,
        StRunning = 3'b010,
        StDone    = 3'b001
    } state_e;

    localparam logic [15:0] HoldLast = 16'(RST_HOLD_CYCLES - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [15:0]           r_hold;
    logic [15:0]           w_hold_next;
    logic [CFG_WIDTH-1:0]  r_cfg;
    logic [TIME_WIDTH-1:0] r_start;
    logic [TIME_WIDTH-1:0] r_stop;
    logic [CNT_WIDTH-1:0]  r_run_steps;
    logic                  r_emu_rst;
    logic                  r_emu_en;
    logic                  r_record_en;
    logic                  r_done_pulse;

    logic                  w_hit_stop;
    logic                  w_hit_start;
    logic                  w_count;

    assign w_hit_stop  = bus.time_adv && (bus.time_curr >= r_stop);
    assign w_hit_start = bus.time_adv && (bus.time_curr >= r_start);

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_count      = 1'b0;
        unique case (r_state)
            StInReset: begin
                if (bus.soft_restart) begin
                    w_hold_next = '0;
                end else if (r_hold == HoldLast) begin
                    w_state_next = StWaiting;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold + 16'd1;
                end
            end
            StWaiting: begin
                if (bus.soft_restart) begin
                    w_state_next = StInReset;
                    w_hold_next  = '0;
                end else if (w_hit_stop) begin
                    w_state_next = StDone;
                end else if (w_hit_start) begin
                    // The strobe that opens the recording window is itself a run step.
                    w_state_next = StRunning;
                    w_count      = 1'b1;
                end
            end
            StRunning: begin
                if (bus.soft_restart) begin
                    w_state_next = StInReset;
                    w_hold_next  = '0;
                end else begin
                    w_count = bus.time_adv;
                    if (w_hit_stop) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.soft_restart) begin
                    w_state_next = StInReset;
                    w_hold_next  = '0;
                end
            end
            default: begin
                w_state_next = StInReset;
                w_hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StInReset;
            r_hold       <= '0;
            r_cfg        <= '0;
            r_start      <= '0;
            r_stop       <= '0;
            r_run_steps  <= '0;
            r_emu_rst    <= 1'b1;
            r_emu_en     <= 1'b0;
            r_record_en  <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            // Settings are only transparent while the datapath is held in reset.
            if (r_state == StInReset) begin
                r_cfg   <= bus.cfg_ext;
                r_start <= bus.start_time_ext;
                r_stop  <= bus.stop_time_ext;
            end
            if (w_state_next == StInReset) begin
                r_run_steps <= '0;
            end else if (w_count && !(&r_run_steps)) begin
                r_run_steps <= r_run_steps + 1'b1;
            end
            r_emu_rst    <= (w_state_next == StInReset);
            r_emu_en     <= (w_state_next == StWaiting) || (w_state_next == StRunning);
            r_record_en  <= (w_state_next == StRunning);
            r_done_pulse <= (w_state_next == StDone) && (r_state != StDone);
        end
    end

    assign bus.run_state  = r_state;
    assign bus.emu_rst    = r_emu_rst;
    assign bus.emu_en     = r_emu_en;
    assign bus.record_en  = r_record_en;
    assign bus.done_pulse = r_done_pulse;
    assign bus.cfg        = r_cfg;
    assign bus.run_steps  = r_run_steps;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed plus randomized bench for emu_run_ctrl against a phase-level reference model.
module tb_emu_run_ctrl;

    localparam int unsigned TW   = 64;
    localparam int unsigned CW   = 64;
    localparam int unsigned NW   = 32;
    localparam int unsigned HOLD = 4;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DONE  = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    emu_run_ctrl_if #(.TIME_WIDTH(TW), .CFG_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

    emu_run_ctrl #(
        .TIME_WIDTH     (TW),
        .CFG_WIDTH      (CW),
        .RST_HOLD_CYCLES(HOLD),
        .CNT_WIDTH      (NW)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which phase we are in, how long we have sat in reset, latched settings.
    int              m_phase;
    int              m_cycles_in_reset;
    logic [CW-1:0]   m_cfg;
    logic [TW-1:0]   m_start;
    logic [TW-1:0]   m_stop;
    longint unsigned m_steps;
    bit              m_pulse;

    function automatic logic [2:0] phase_code(input int ph);
        case (ph)
            PH_RESET: return 3'b100;
            PH_WAIT:  return 3'b000;
            PH_RUN:   return 3'b010;
            default:  return 3'b001;
        endcase
    endfunction

    task automatic m_reset();
        m_phase = PH_RESET; m_cycles_in_reset = 0;
        m_cfg = '0; m_start = '0; m_stop = '0; m_steps = 0; m_pulse = 0;
    endtask

    task automatic m_count();
        if (m_steps < 64'hFFFF_FFFF) m_steps++;
    endtask

    // One rising edge of the model, using the inputs as they were before the edge.
    task automatic model_step();
        int prev = m_phase;
        if (m_phase == PH_RESET) begin
            m_cfg = bus.cfg_ext; m_start = bus.start_time_ext; m_stop = bus.stop_time_ext;
            m_steps = 0;
            if (bus.soft_restart) m_cycles_in_reset = 0;
            else if (m_cycles_in_reset + 1 >= HOLD) begin
                m_phase = PH_WAIT; m_cycles_in_reset = 0;
            end else m_cycles_in_reset++;
        end else if (bus.soft_restart) begin
            m_phase = PH_RESET; m_cycles_in_reset = 0; m_steps = 0;
        end else if (bus.time_adv) begin
            if (m_phase == PH_WAIT) begin
                if (bus.time_curr >= m_stop) m_phase = PH_DONE;
                else if (bus.time_curr >= m_start) begin
                    m_phase = PH_RUN; m_count();
                end
            end else if (m_phase == PH_RUN) begin
                m_count();
                if (bus.time_curr >= m_stop) m_phase = PH_DONE;
            end
        end
        m_pulse = (m_phase == PH_DONE) && (prev != PH_DONE);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("run_state",  64'(bus.run_state),  64'(phase_code(m_phase)));
        chk("emu_rst",    64'(bus.emu_rst),    64'(m_phase == PH_RESET));
        chk("emu_en",     64'(bus.emu_en),     64'(m_phase == PH_WAIT || m_phase == PH_RUN));
        chk("record_en",  64'(bus.record_en),  64'(m_phase == PH_RUN));
        chk("done_pulse", 64'(bus.done_pulse), 64'(m_pulse));
        chk("cfg",        64'(bus.cfg),        64'(m_cfg));
        chk("run_steps",  64'(bus.run_steps),  m_steps);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic restart(input logic [63:0] cfg_v, input logic [63:0] st, input logic [63:0] sp);
        bus.cfg_ext = cfg_v; bus.start_time_ext = st; bus.stop_time_ext = sp;
        bus.time_adv = 1'b0; bus.soft_restart = 1'b1;
        tick();
        bus.soft_restart = 1'b0;
        repeat (HOLD) tick();
    endtask

    initial begin
        logic [63:0] tc;
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.cfg_ext = '0; bus.start_time_ext = '0; bus.stop_time_ext = '0;
        bus.time_curr = '0; bus.time_adv = 1'b0; bus.soft_restart = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check_outputs();

        // Hold stretch, then a normal 100..200 run.
        bus.cfg_ext = 64'hA5; bus.start_time_ext = 64'd100; bus.stop_time_ext = 64'd200;
        rst_n = 1'b1;
        repeat (HOLD) begin
            chk("hold_emu_rst", 64'(bus.emu_rst), 64'd1);
            tick();
        end
        chk("wait_after_hold", 64'(bus.run_state), 64'h0);
        bus.cfg_ext = 64'h0;
        for (int i = 0; i <= 20; i++) begin
            bus.time_curr = 64'(i * 10); bus.time_adv = 1'b1;
            tick();
        end
        chk("done_code", 64'(bus.run_state), 64'h1);
        chk("done_pulse_first", 64'(bus.done_pulse), 64'd1);
        bus.time_adv = 1'b0;
        tick();
        chk("done_pulse_once", 64'(bus.done_pulse), 64'd0);
        chk("steps_100_200", 64'(bus.run_steps), 64'd11);
        chk("cfg_frozen", 64'(bus.cfg), 64'hA5);

        // Soft restart pulsed while running.
        restart(64'h5A, 64'd100, 64'd200);
        bus.time_curr = 64'd150; bus.time_adv = 1'b1;
        tick();
        chk("running", 64'(bus.run_state), 64'h2);
        bus.time_adv = 1'b0; bus.cfg_ext = 64'hC3;
        bus.start_time_ext = 64'd300; bus.stop_time_ext = 64'd200;
        bus.soft_restart = 1'b1;
        tick();
        bus.soft_restart = 1'b0;
        chk("soft_state", 64'(bus.run_state), 64'h4);
        chk("soft_rec", 64'(bus.record_en), 64'd0);
        chk("soft_steps", 64'(bus.run_steps), 64'd0);
        repeat (HOLD) tick();
        chk("new_cfg", 64'(bus.cfg), 64'hC3);

        // Stop below start, with idle time_curr beyond both.
        bus.time_curr = 64'd500;
        repeat (10) tick();
        chk("idle_no_adv", 64'(bus.run_state), 64'h0);
        bus.time_curr = 64'd200; bus.time_adv = 1'b1;
        tick();
        bus.time_adv = 1'b0;
        chk("stop_priority", 64'(bus.run_state), 64'h1);
        chk("no_steps", 64'(bus.run_steps), 64'd0);

        // start=0 enters on first strobe; async reset mid-run.
        restart(64'h77, 64'd0, 64'd1000);
        bus.time_curr = 64'd5; bus.time_adv = 1'b1;
        repeat (3) tick();
        chk("start_zero", 64'(bus.run_state), 64'h2);
        #2 rst_n = 1'b0;
        #1 m_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1; bus.time_adv = 1'b0;

        // Randomized run sequences.
        tc = '0;
        for (int i = 0; i < 2000; i++) begin
            bus.soft_restart = ($urandom_range(0, 63) == 0) ||
                               (m_phase == PH_DONE && $urandom_range(0, 3) == 0);
            if (m_phase == PH_RESET) begin
                tc = '0;
                bus.cfg_ext = {$urandom, $urandom};
                bus.start_time_ext = 64'($urandom_range(0, 400));
                bus.stop_time_ext = 64'($urandom_range(0, 600));
            end
            bus.time_adv = 1'($urandom_range(0, 1));
            if (bus.time_adv) tc = tc + 64'($urandom_range(0, 30));
            bus.time_curr = bus.time_adv ? tc : 64'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emu_run_ctrl.md
Name: emu_run_ctrl

Overview:
- Run-state sequencer for the link emulator. Holds the emulated datapath in reset for a fixed stretch, latches the VIO/testbench settings, and enables emulated-time advance.
- Gates loopback-tester recording between start_time and stop_time, and reports run_state as IN_RESET/WAITING/RUNNING/DONE.
- Sits between the external settings/reset and the datapath (TX, channel, RX, DCO, loop filter, loopback tester).

Parameters:
TIME_WIDTH, 64, width of emulated time values (unsigned)
CFG_WIDTH, 64, width of the bundled settings word (rx/tx setting, dco_init, kp/ki, loopback_offset, jitter scales)
RST_HOLD_CYCLES, 16, number of clk cycles emu_rst stays asserted after each entry to IN_RESET; legal range 1..65535
CNT_WIDTH, 32, width of run_steps

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_ext  in  CFG_WIDTH  raw settings from VIO/testbench
start_time_ext  in  TIME_WIDTH  time at which recording begins
stop_time_ext  in  TIME_WIDTH  time at which emulation ends
time_curr  in  TIME_WIDTH  current emulated time from datapath
time_adv  in  1  one-cycle strobe: time_curr updated this cycle
soft_restart  in  1  level; forces a return to IN_RESET
emu_rst  out  1  synchronous reset to emulated datapath
emu_en  out  1  step enable to emulated datapath
cfg  out  CFG_WIDTH  latched settings, stable outside IN_RESET
record_en  out  1  loopback-tester record enable
run_state  out  3  state code: IN_RESET=3'b100, WAITING=3'b000, RUNNING=3'b010, DONE=3'b001
done_pulse  out  1  one-cycle pulse on entry to DONE
run_steps  out  CNT_WIDTH  count of time_adv strobes seen while RUNNING; saturates at all-ones

Behaviour:
Reset values (rst_n=0, asynchronous):
- run_state=IN_RESET, emu_rst=1, emu_en=0, record_en=0, done_pulse=0, cfg=0, run_steps=0.
- Hold counter=0; start/stop registers=0.

All outputs are registered and update one clk cycle after the causing input is sampled.

IN_RESET:
- emu_rst=1, emu_en=0, record_en=0.
- Every cycle: cfg<=cfg_ext, start_reg<=start_time_ext, stop_reg<=stop_time_ext, run_steps<=0.
- Hold counter increments each cycle. When it equals RST_HOLD_CYCLES-1, go to WAITING next cycle. With rst_n high, emu_rst is therefore 1 for exactly RST_HOLD_CYCLES cycles.
- cfg, start_reg and stop_reg are frozen in every other state.

WAITING:
- emu_rst=0, emu_en=1, record_en=0.
- On time_adv with time_curr>=stop_reg: go to DONE. Stop has priority over start.
- Else on time_adv with time_curr>=start_reg: go to RUNNING.
- time_curr is ignored when time_adv=0.

RUNNING:
- emu_en=1, record_en=1.
- Each time_adv: run_steps increments (saturating).
- On time_adv with time_curr>=stop_reg: go to DONE. The strobe that causes the exit is still counted.

DONE:
- emu_en=0, record_en=0, emu_rst=0; datapath state is held for readout.
- done_pulse=1 only on the first cycle in DONE.
- Remains in DONE until soft_restart or reset.

soft_restart=1 in any state other than IN_RESET:
- Next state is IN_RESET, hold counter cleared to 0, record_en and emu_en drop on the same edge.
- soft_restart held high keeps the block in IN_RESET with the counter held at 0.
- soft_restart has priority over all time-based transitions in the same cycle.

Arithmetic and corner cases:
- All comparisons are unsigned full-width.
- start_reg=0 enters RUNNING on the first time_adv.
- stop_reg<=start_reg never records.
- rst_n assertion mid-run returns immediately (asynchronously) to the reset values.

Test Plan:
- RST_HOLD_CYCLES=4, rst_n released at cycle 0, cfg_ext=64'hA5 -> emu_rst high for exactly cycles 0..3, run_state=000 at cycle 4, cfg=64'hA5 and unchanged after cfg_ext changes to 0.
- start=100, stop=200, time_adv every cycle with time_curr=0,10,20,... -> RUNNING on the cycle after time_curr=100. DONE and done_pulse (1 cycle) after time_curr=200. run_steps=11. record_en high exactly while run_state=010.
- start=300, stop=200 -> WAITING goes straight to DONE on the strobe with time_curr=200; record_en never asserts; run_steps=0.
- time_adv low with time_curr=500 (> start and stop) for 10 cycles -> state unchanged; the first strobe triggers the transition.
- soft_restart pulsed 1 cycle while RUNNING -> IN_RESET next cycle, record_en=0, emu_rst high 4 cycles, run_steps=0, new cfg_ext latched.
- rst_n asserted while RUNNING -> asynchronous return to run_state=100, all outputs at reset values without a clk edge.
